// File: rtl/xnor_match_n.sv
// xnor_match_n: two-stage masked XNOR compare with saturating equal-run counter and threshold HIT flag.
// Define XNOR_MATCH_STICKY_HIT_EN to make HIT sticky until CLR or reset.
module xnor_match_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] MASK,
  input  logic [CNT_W-1:0] THRESH,
  input  logic             CLR,
  output logic [WIDTH-1:0] Y,
  output logic             EQ,
  output logic             VALID,
  output logic [CNT_W-1:0] RUN,
  output logic             HIT
);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  logic [WIDTH-1:0] y_q, y_d, mask_q, mask_d;
  logic [CNT_W-1:0] run_q, run_d, run_nxt;
  logic v1_q, eq_q, eq_d, valid_q, hit_q, hit_d, eq_new, hc;
  always_comb begin
    y_d     = EN ? ~(A ^ B) : y_q;
    mask_d  = EN ? MASK : mask_q;
    eq_new  = &(y_q | ~mask_q);
    eq_d    = v1_q ? eq_new : eq_q;
    run_nxt = eq_new ? ((run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1)) : '0;
    hc      = (THRESH != '0) && (run_nxt >= THRESH);
    run_d   = CLR ? '0 : v1_q ? run_nxt : run_q;
`ifdef XNOR_MATCH_STICKY_HIT_EN
    hit_d   = CLR ? 1'b0 : v1_q ? (hit_q | hc) : hit_q;
`else
    hit_d   = CLR ? 1'b0 : v1_q ? hc : hit_q;
`endif
  end
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      y_q     <= '0;
      mask_q  <= '0;
      v1_q    <= 1'b0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
      run_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      mask_q  <= mask_d;
      v1_q    <= EN;
      eq_q    <= eq_d;
      valid_q <= v1_q;
      run_q   <= run_d;
      hit_q   <= hit_d;
    end
  end
  assign Y     = y_q;
  assign EQ    = eq_q;
  assign VALID = valid_q;
  assign RUN   = run_q;
  assign HIT   = hit_q;
endmodule

// File: tb/tb_xnor_match_n.sv
// tb_xnor_match_n: scoreboard bench for xnor_match_n (defaults WIDTH=8, CNT_W=4).
module tb_xnor_match_n;
`ifdef XNOR_MATCH_STICKY_HIT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  typedef struct {logic eq; int run; logic hit; int due;} exp_t;
  logic clk = 0, rst_n, en, clr, eq, valid, hit;
  logic [7:0] a, b, mask, y;
  logic [3:0] thresh, run;
  int tests = 0, fails = 0, cyc = 0;
  exp_t q[$];
  int m_run = 0;
  logic m_hit = 0, pend = 0;
  logic [7:0] pa, pb, pm, exp_y = 0;
  xnor_match_n dut (.CLK(clk), .R(rst_n), .EN(en), .A(a), .B(b), .MASK(mask), .THRESH(thresh),
    .CLR(clr), .Y(y), .EQ(eq), .VALID(valid), .RUN(run), .HIT(hit));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t it;
    if (valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        it = q.pop_front();
        chk("latency", cyc, it.due);
        chk("EQ", eq, it.eq);
        chk("RUN", run, it.run);
        chk("HIT", hit, it.hit);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("missing_valid", 0, 1);
      void'(q.pop_front());
    end
  end
  // Model: a sample issued at one edge resolves at the next, using CLR/THRESH present then.
  task automatic step(input logic e, input logic [7:0] ia, ib, im, input logic [3:0] th, input logic c);
    logic r_eq, hc;
    @(negedge clk);
    en = e; a = ia; b = ib; mask = im; thresh = th; clr = c;
    if (pend) begin
      r_eq = ((pa ^ pb) & pm) == 8'h00;
      if (c) begin
        m_run = 0;
        m_hit = 0;
      end else begin
        m_run = r_eq ? ((m_run + 1 > 15) ? 15 : m_run + 1) : 0;
        hc = (th != 0) && (m_run >= th);
        m_hit = STICKY ? (m_hit | hc) : hc;
      end
      q.push_back('{r_eq, m_run, m_hit, cyc + 1});
    end else if (c) begin
      m_run = 0;
      m_hit = 0;
    end
    pend = e;
    if (e) begin
      pa = ia; pb = ib; pm = im;
      exp_y = ~(ia ^ ib);
    end
    @(posedge clk);
    #1;
    chk("Y", y, exp_y);
    chk("RUN_now", run, m_run);
    chk("HIT_now", hit, m_hit);
  endtask
  task automatic idle(input int n, input logic [3:0] th);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, th, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("rst_Y", y, 0);
    chk("rst_EQ", eq, 0);
    chk("rst_VALID", valid, 0);
    chk("rst_RUN", run, 0);
    chk("rst_HIT", hit, 0);
    m_run = 0; m_hit = 0; pend = 0; exp_y = 0;
    q.delete();
    en = 0; clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    logic [7:0] ra;
    rst_n = 0; en = 0; clr = 0; a = 0; b = 0; mask = 0; thresh = 0;
    #1;
    chk("init_Y", y, 0);
    chk("init_VALID", valid, 0);
    chk("init_RUN", run, 0);
    chk("init_HIT", hit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(1, 8'hA5, 8'h5A, 8'hFF, 0, 0);
    idle(2, 0);
    step(1, 8'h3C, 8'h3D, 8'hFE, 0, 0);
    step(1, 8'h3C, 8'h3D, 8'h00, 0, 0);
    step(1, 8'h3C, 8'h3D, 8'hFF, 0, 0);
    idle(2, 0);
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      step(1, ra, ra, 8'hFF, 0, 0);
    end
    step(1, 8'h01, 8'h00, 8'hFF, 0, 0);
    idle(2, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h77, 8'h77, 8'hFF, 3, 0);
    step(1, 8'h77, 8'h76, 8'hFF, 3, 0);
    idle(3, 3);
    step(0, 0, 0, 0, 3, 1);
    idle(1, 3);
    for (int i = 0; i < 10; i++) step(1, 8'h11, 8'h11, 8'hFF, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h42, 8'h42, 8'hF0, 0, 0);
    idle(2, 0);
    chk("run_before_reset", run, 5);
    pulse_reset();
    step(1, 8'h9C, 8'h9C, 8'hFF, 0, 0);
    idle(3, 0);
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      step($urandom_range(0, 3) != 0, ra,
           ra ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00),
           ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom),
           4'($urandom_range(0, 6)), $urandom_range(0, 19) == 0);
      if (i == 200) pulse_reset();
    end
    idle(4, 0);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
